// File: rtl/sisc_pkg.sv
// -----------------------------------------------------------------------------
// sisc_pkg
// Shared definitions for the SISC processor: default instruction address
// width, the HALT opcode encoding and the instruction-fetch state encoding.
// Imported by ir_fetch, pc_reg, the core and the memory model.
// -----------------------------------------------------------------------------
package sisc_pkg;

   // Default instruction address width, in words.
   localparam int DEFAULT_ADDR_W = 16;

   // Opcode field value (instruction bits [31:28]) that stops fetch when the
   // halt feature is built in.
   localparam logic [3:0] OPCODE_HALT = 4'hF;

   // Fetch unit states. HALT is only reachable when the halt feature is built.
   typedef enum logic [1:0] {
      RESET = 2'd0,
      FETCH = 2'd1,
      READY = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

endpackage : sisc_pkg

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register: synchronous reset-load, parallel load and
// increment (modulo 2^ADDR_W). LD has priority over INC.
//
// Ports:
//   CLK  in   1       clock, rising edge
//   RST  in   1       synchronous active-high reset, loads RESET_PC
//   LD   in   1       load D
//   INC  in   1       increment by one (wraps to 0)
//   D    in   ADDR_W  parallel load value
//   Q    out  ADDR_W  current PC
// -----------------------------------------------------------------------------
module pc_reg
   import sisc_pkg::*;
#(
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LD,
   input  logic              INC,
   input  logic [ADDR_W-1:0] D,
   output logic [ADDR_W-1:0] Q
);

   // NOTE: clocked state uses non-blocking (<=) so every register samples the
   // pre-edge values of its inputs; blocking here would create order-dependent
   // simulation races between always_ff blocks.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Q <= RESET_PC;
      end else if (LD) begin
         Q <= D;
      end else if (INC) begin
         Q <= Q + ADDR_W'(1);
      end
   end

endmodule : pc_reg

// File: rtl/ir_fetch.sv
// -----------------------------------------------------------------------------
// ir_fetch
// Instruction fetch unit for the SISC processor. Owns the program counter,
// reads instruction words over a request/acknowledge handshake and holds the
// fetched word in IR for the core. The core advances or redirects fetch with
// PC_WRITE / BR_TAKEN / BR_ADDR.
//
// Build option:
//   IR_FETCH_HALT_EN  when defined, a captured word whose opcode field equals
//                     OPCODE_HALT parks the unit in HALT until reset; when not
//                     defined that opcode is ordinary and HALTED is tied to 0.
//
// Ports:
//   CLK       in   1       clock, rising edge
//   RST       in   1       synchronous active-high reset
//   PC_WRITE  in   1       core consumed IR, fetch the next word
//   BR_TAKEN  in   1       with PC_WRITE: next PC is BR_ADDR
//   BR_ADDR   in   ADDR_W  absolute branch target (word address)
//   IM_REQ    out  1       instruction memory read request
//   IM_ADDR   out  ADDR_W  read address (equals PC)
//   IM_ACK    in   1       memory returns IM_DATA this cycle
//   IM_DATA   in   32      instruction word from memory
//   IR        out  32      held instruction word
//   IR_VALID  out  1       IR holds a fetched instruction
//   PC        out  ADDR_W  address of IR's word, or of the word being fetched
//   HALTED    out  1       unit is parked in HALT
// -----------------------------------------------------------------------------
module ir_fetch
   import sisc_pkg::*;
#(
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PC_WRITE,
   input  logic              BR_TAKEN,
   input  logic [ADDR_W-1:0] BR_ADDR,
   output logic              IM_REQ,
   output logic [ADDR_W-1:0] IM_ADDR,
   input  logic              IM_ACK,
   input  logic [31:0]       IM_DATA,
   output logic [31:0]       IR,
   output logic              IR_VALID,
   output logic [ADDR_W-1:0] PC,
   output logic              HALTED
);

   fetch_state_t state, state_next;
   logic         pc_ld, pc_inc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .CLK (CLK),
      .RST (RST),
      .LD  (pc_ld),
      .INC (pc_inc),
      .D   (BR_ADDR),
      .Q   (PC)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= RESET;
      end else begin
         state <= state_next;
      end
   end

   // Capture only while a request is outstanding; a late acknowledge arriving
   // in any other state leaves IR untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         IR <= 32'h0;
      end else if (state == FETCH && IM_ACK) begin
         IR <= IM_DATA;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves it unassigned and no latch is inferred.
      state_next = state;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      case (state)
         RESET: state_next = FETCH;
         FETCH: begin
            if (IM_ACK) begin
`ifdef IR_FETCH_HALT_EN
               state_next = (IM_DATA[31:28] == OPCODE_HALT) ? HALT : READY;
`else
               state_next = READY;
`endif
            end
         end
         READY: begin
            if (PC_WRITE) begin
               state_next = FETCH;
               pc_ld      = BR_TAKEN;
               pc_inc     = ~BR_TAKEN;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = RESET;
      endcase
   end

   // All outputs come from registers or from the state decode only.
   assign IM_REQ   = (state == FETCH);
   assign IM_ADDR  = PC;
   assign IR_VALID = (state == READY) || (state == HALT);
`ifdef IR_FETCH_HALT_EN
   assign HALTED   = (state == HALT);
`else
   assign HALTED   = 1'b0;
`endif

endmodule : ir_fetch

// File: tb/tb_ir_fetch.sv
// -----------------------------------------------------------------------------
// tb_ir_fetch
// Directed bench for ir_fetch. Inputs are driven and outputs sampled on the
// falling clock edge; the bench plays the instruction memory itself.
// -----------------------------------------------------------------------------
module tb_ir_fetch;
   import sisc_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        PC_WRITE;
   logic        BR_TAKEN;
   logic [15:0] BR_ADDR;
   logic        IM_REQ;
   logic [15:0] IM_ADDR;
   logic        IM_ACK;
   logic [31:0] IM_DATA;
   logic [31:0] IR;
   logic        IR_VALID;
   logic [15:0] PC;
   logic        HALTED;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   ir_fetch #(
      .ADDR_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PC_WRITE (PC_WRITE),
      .BR_TAKEN (BR_TAKEN),
      .BR_ADDR  (BR_ADDR),
      .IM_REQ   (IM_REQ),
      .IM_ADDR  (IM_ADDR),
      .IM_ACK   (IM_ACK),
      .IM_DATA  (IM_DATA),
      .IR       (IR),
      .IR_VALID (IR_VALID),
      .PC       (PC),
      .HALTED   (HALTED)
   );

   function automatic logic [31:0] data_for(input logic [15:0] addr);
      return {16'hA5C3, addr};
   endfunction

   task automatic tick();
      @(negedge CLK);
   endtask

   // Serve one outstanding request after 'waits' idle cycles, checking the
   // request is held stable and IR is untouched until the acknowledge.
   task automatic do_fetch(input string name, input logic [15:0] addr, input logic [31:0] data,
                           input int waits, input logic [31:0] prev_ir, input logic exp_halt);
      for (int i = 0; i <= waits; i++) begin
         vectors++; if (IM_REQ !== 1'b1) begin miscompares++; $display("FAIL %s im_req[%0d] got=%b exp=1", name, i, IM_REQ); end
         vectors++; if (IM_ADDR !== addr) begin miscompares++; $display("FAIL %s im_addr[%0d] got=%h exp=%h", name, i, IM_ADDR, addr); end
         vectors++; if (IR !== prev_ir) begin miscompares++; $display("FAIL %s ir_hold[%0d] got=%h exp=%h", name, i, IR, prev_ir); end
         vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL %s ir_valid[%0d] got=%b exp=0", name, i, IR_VALID); end
         IM_ACK  = (i == waits);
         IM_DATA = (i == waits) ? data : 32'h0BAD_0BAD;
         tick();
      end
      IM_ACK  = 1'b0;
      IM_DATA = 32'h0BAD_0BAD;
      vectors++; if (IR !== data) begin miscompares++; $display("FAIL %s ir got=%h exp=%h", name, IR, data); end
      vectors++; if (IR_VALID !== 1'b1) begin miscompares++; $display("FAIL %s ir_valid got=%b exp=1", name, IR_VALID); end
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL %s im_req_done got=%b exp=0", name, IM_REQ); end
      vectors++; if (PC !== addr) begin miscompares++; $display("FAIL %s pc got=%h exp=%h", name, PC, addr); end
      vectors++; if (HALTED !== exp_halt) begin miscompares++; $display("FAIL %s halted got=%b exp=%b", name, HALTED, exp_halt); end
   endtask

   // One-cycle PC_WRITE pulse from READY; IR_VALID must drop the next cycle.
   task automatic pulse(input logic br, input logic [15:0] addr);
      PC_WRITE = 1'b1;
      BR_TAKEN = br;
      BR_ADDR  = addr;
      tick();
      PC_WRITE = 1'b0;
      BR_TAKEN = 1'b0;
      vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL pulse ir_valid got=%b exp=0", IR_VALID); end
   endtask

   task automatic test_reset();
      tick();
      tick();
      vectors++; if (PC !== 16'h0) begin miscompares++; $display("FAIL rst pc got=%h exp=0000", PC); end
      vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL rst ir got=%h exp=00000000", IR); end
      vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL rst ir_valid got=%b exp=0", IR_VALID); end
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL rst im_req got=%b exp=0", IM_REQ); end
      vectors++; if (IM_ADDR !== 16'h0) begin miscompares++; $display("FAIL rst im_addr got=%h exp=0000", IM_ADDR); end
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL rst halted got=%b exp=0", HALTED); end
      RST = 1'b0;
      tick();
      vectors++; if (IM_REQ !== 1'b1) begin miscompares++; $display("FAIL first_req im_req got=%b exp=1", IM_REQ); end
      do_fetch("first_fetch", 16'h0000, 32'h1234_5678, 0, 32'h0, 1'b0);
   endtask

   task automatic test_stream();
      logic [31:0] prev = 32'h1234_5678;
      for (int k = 1; k <= 4; k++) begin
         pulse(1'b0, 16'h0);
         do_fetch("stream", 16'(k), data_for(16'(k)), 3, prev, 1'b0);
         prev = data_for(16'(k));
      end
   endtask

   task automatic test_branch();
      pulse(1'b0, 16'h0);
      do_fetch("pc5", 16'h0005, data_for(16'h0005), 0, data_for(16'h0004), 1'b0);
      BR_TAKEN = 1'b1;
      BR_ADDR  = 16'h0040;
      tick();
      BR_TAKEN = 1'b0;
      vectors++; if (PC !== 16'h0005) begin miscompares++; $display("FAIL br_no_write pc got=%h exp=0005", PC); end
      vectors++; if (IR_VALID !== 1'b1) begin miscompares++; $display("FAIL br_no_write ir_valid got=%b exp=1", IR_VALID); end
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL br_no_write im_req got=%b exp=0", IM_REQ); end
      pulse(1'b1, 16'h0040);
      do_fetch("branch", 16'h0040, data_for(16'h0040), 1, data_for(16'h0005), 1'b0);
   endtask

   task automatic test_wrap_ignored();
      pulse(1'b1, 16'hFFFF);
      do_fetch("pc_ffff", 16'hFFFF, data_for(16'hFFFF), 0, data_for(16'h0040), 1'b0);
      pulse(1'b0, 16'h0);
      PC_WRITE = 1'b1;
      BR_TAKEN = 1'b1;
      BR_ADDR  = 16'h1234;
      tick();
      tick();
      PC_WRITE = 1'b0;
      BR_TAKEN = 1'b0;
      vectors++; if (PC !== 16'h0000) begin miscompares++; $display("FAIL wr_in_fetch pc got=%h exp=0000", PC); end
      do_fetch("wrap", 16'h0000, data_for(16'h0000), 0, data_for(16'hFFFF), 1'b0);
      IM_ACK  = 1'b1;
      IM_DATA = 32'hCAFE_F00D;
      tick();
      IM_ACK  = 1'b0;
      vectors++; if (IR !== 32'hA5C3_0000) begin miscompares++; $display("FAIL stray_ack ir got=%h exp=a5c30000", IR); end
      vectors++; if (IR_VALID !== 1'b1) begin miscompares++; $display("FAIL stray_ack ir_valid got=%b exp=1", IR_VALID); end
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL stray_ack im_req got=%b exp=0", IM_REQ); end
   endtask

   task automatic test_reset_mid_fetch();
      pulse(1'b0, 16'h0);
      vectors++; if (IM_ADDR !== 16'h0001) begin miscompares++; $display("FAIL mid_rst pre im_addr got=%h exp=0001", IM_ADDR); end
      RST = 1'b1;
      tick();
      RST     = 1'b0;
      IM_ACK  = 1'b1;
      IM_DATA = 32'hDEAD_BEEF;
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL mid_rst im_req got=%b exp=0", IM_REQ); end
      vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL mid_rst ir got=%h exp=00000000", IR); end
      vectors++; if (IR_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_rst ir_valid got=%b exp=0", IR_VALID); end
      vectors++; if (PC !== 16'h0000) begin miscompares++; $display("FAIL mid_rst pc got=%h exp=0000", PC); end
      tick();
      IM_ACK = 1'b0;
      vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL late_ack ir got=%h exp=00000000", IR); end
      vectors++; if (IM_REQ !== 1'b1) begin miscompares++; $display("FAIL restart im_req got=%b exp=1", IM_REQ); end
      vectors++; if (IM_ADDR !== 16'h0000) begin miscompares++; $display("FAIL restart im_addr got=%h exp=0000", IM_ADDR); end
      // Reset and acknowledge on the same edge: reset wins.
      RST     = 1'b1;
      IM_ACK  = 1'b1;
      IM_DATA = 32'h1111_2222;
      tick();
      RST    = 1'b0;
      IM_ACK = 1'b0;
      vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL rst_vs_ack ir got=%h exp=00000000", IR); end
      vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL rst_vs_ack im_req got=%b exp=0", IM_REQ); end
      tick();
      do_fetch("refetch", 16'h0000, 32'h1234_5678, 1, 32'h0, 1'b0);
   endtask

   task automatic test_halt();
      pulse(1'b0, 16'h0);
`ifdef IR_FETCH_HALT_EN
      do_fetch("halt_word", 16'h0001, 32'hF000_0000, 0, 32'h1234_5678, 1'b1);
      for (int i = 0; i < 20; i++) begin
         PC_WRITE = (i % 2 == 0);
         tick();
         vectors++; if (IM_REQ !== 1'b0) begin miscompares++; $display("FAIL halt im_req[%0d] got=%b exp=0", i, IM_REQ); end
         vectors++; if (HALTED !== 1'b1) begin miscompares++; $display("FAIL halt halted[%0d] got=%b exp=1", i, HALTED); end
         vectors++; if (IR_VALID !== 1'b1) begin miscompares++; $display("FAIL halt ir_valid[%0d] got=%b exp=1", i, IR_VALID); end
      end
      PC_WRITE = 1'b0;
      vectors++; if (IR !== 32'hF000_0000) begin miscompares++; $display("FAIL halt ir got=%h exp=f0000000", IR); end
      vectors++; if (PC !== 16'h0001) begin miscompares++; $display("FAIL halt pc got=%h exp=0001", PC); end
`else
      do_fetch("f_opcode", 16'h0001, 32'hF000_0000, 0, 32'h1234_5678, 1'b0);
      pulse(1'b0, 16'h0);
      vectors++; if (IM_REQ !== 1'b1) begin miscompares++; $display("FAIL f_opcode next im_req got=%b exp=1", IM_REQ); end
      vectors++; if (IM_ADDR !== 16'h0002) begin miscompares++; $display("FAIL f_opcode next im_addr got=%h exp=0002", IM_ADDR); end
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL f_opcode halted got=%b exp=0", HALTED); end
`endif
   endtask

   initial begin
      RST      = 1'b1;
      PC_WRITE = 1'b0;
      BR_TAKEN = 1'b0;
      BR_ADDR  = 16'h0;
      IM_ACK   = 1'b0;
      IM_DATA  = 32'h0;
      test_reset();
      test_stream();
      test_branch();
      test_wrap_ignored();
      test_reset_mid_fetch();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_ir_fetch
